// File: rtl/wb_bram_burst.sv
// wb_bram_burst: Wishbone block-RAM slave with zero-wait writes and prefetching
// incrementing/wrapping burst reads. Define WB_BRAM_ADR_CHECK_EN to answer out-of-range addresses with err.
module wb_bram_burst #(
  parameter int MEM_ADR_WIDTH = 11,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cyc,
  input  logic                    stb,
  input  logic                    we,
  input  logic [31:0]             adr,
  input  logic [DATA_WIDTH/8-1:0] sel,
  input  logic [DATA_WIDTH-1:0]   dat_ms,
  input  logic [2:0]              cti,
  input  logic [1:0]              bte,
  output logic [DATA_WIDTH-1:0]   dat_sm,
  output logic                    ack,
  output logic                    err,
  output logic                    rty
);
  localparam int LANES = DATA_WIDTH / 8;
  localparam int B     = $clog2(LANES);
  localparam int TOP   = MEM_ADR_WIDTH + B;  // first byte-address bit above the array
  localparam int DEPTH = 2 ** MEM_ADR_WIDTH;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  typedef enum logic [1:0] {IDLE, RD_WAIT, BURST} state_t;
  typedef logic [MEM_ADR_WIDTH-1:0] word_t;

  state_t state, state_nxt;
  word_t  pred, pred_nxt;      // word whose data is currently held in dat_sm
  logic   rd_err, rd_err_nxt;  // pending read was out of range
  logic   rd_en;
  word_t  rd_word;
  word_t  word;
  word_t  word_inc;
  logic   oor;
  logic   wr_req;
  logic   wr_en;
  logic   unused_adr;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign word = adr[TOP-1:B];

`ifdef WB_BRAM_ADR_CHECK_EN
  assign oor        = |adr[31:TOP];
  assign unused_adr = ^adr[B-1:0];
`else
  assign oor        = 1'b0;
  assign unused_adr = ^{adr[31:TOP], adr[B-1:0]};
`endif

  // Wrap bursts only advance the low log2(N) word bits; linear advances all of them.
  function automatic word_t next_word(input word_t w, input logic [1:0] t);
    word_t mask;
    case (t)
      2'b01:   mask = word_t'(3);
      2'b10:   mask = word_t'(7);
      2'b11:   mask = word_t'(15);
      default: mask = '1;
    endcase
    return (w & ~mask) | ((w + word_t'(1)) & mask);
  endfunction

  assign word_inc = next_word(pred, bte);
  assign wr_req   = rst_n & cyc & stb & we;
  assign wr_en    = wr_req & ~oor;
  assign rty      = 1'b0;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      pred   <= '0;
      rd_err <= 1'b0;
    end else begin
      state  <= state_nxt;
      pred   <= pred_nxt;
      rd_err <= rd_err_nxt;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before any branch so no path can infer a latch.
    state_nxt  = state;
    pred_nxt   = pred;
    rd_err_nxt = rd_err;
    rd_en      = 1'b0;
    rd_word    = word;
    ack        = 1'b0;
    err        = 1'b0;
    if (wr_req) begin
      ack       = ~oor;
      err       = oor;
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (cyc && stb) begin
            state_nxt  = RD_WAIT;
            rd_en      = 1'b1;
            pred_nxt   = word;
            rd_err_nxt = oor;
          end
        end
        RD_WAIT: begin
          if (!cyc) begin
            state_nxt = IDLE;
          end else if (stb) begin
            ack = ~rd_err;
            err = rd_err;
            if (!rd_err && cti == CTI_INCR) begin
              state_nxt = BURST;
              pred_nxt  = word_inc;
              rd_en     = 1'b1;
              rd_word   = word_inc;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
        BURST: begin
          if (!cyc) begin
            state_nxt = IDLE;
          end else if (stb) begin
            if (oor) begin
              err       = 1'b1;
              state_nxt = IDLE;
            end else if (word == pred) begin
              ack = 1'b1;
              if (cti == CTI_END || cti == CTI_CLASSIC) begin
                state_nxt = IDLE;
              end else begin
                pred_nxt = word_inc;
                rd_en    = 1'b1;
                rd_word  = word_inc;
              end
            end else begin
              // Master jumped away from the predicted address: restart with a fresh read.
              state_nxt  = RD_WAIT;
              pred_nxt   = word;
              rd_en      = 1'b1;
              rd_err_nxt = 1'b0;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // NOTE: the array itself is never reset; only the read register is, so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < LANES; i++) begin
        if (sel[i]) mem[word][i*8 +: 8] <= dat_ms[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     dat_sm <= '0;
    else if (rd_en) dat_sm <= mem[rd_word];
  end

endmodule

// File: tb/tb_wb_bram_burst.sv
// tb_wb_bram_burst: classic-cycle vector table, hand-written burst corner cases,
// then randomized traffic checked against an array model of the memory.
`timescale 1ns/1ps
module tb_wb_bram_burst;
  localparam int AW    = 11;
  localparam int DEPTH = 1 << AW;
`ifdef WB_BRAM_ADR_CHECK_EN
  localparam bit ADR_CHECK = 1'b1;
`else
  localparam bit ADR_CHECK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc, stb, we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_ms;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [31:0] dat_sm;
  logic        ack, err, rty;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] ref_mem [DEPTH];

  typedef struct {
    bit          we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] wdat;
    logic [31:0] exp;
    bit          exp_err;
  } vec_t;

  vec_t vecs [16];

  always #5 clk = ~clk;

  wb_bram_burst #(.MEM_ADR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .cyc(cyc), .stb(stb), .we(we), .adr(adr),
    .sel(sel), .dat_ms(dat_ms), .cti(cti), .bte(bte), .dat_sm(dat_sm),
    .ack(ack), .err(err), .rty(rty)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic c, input logic s, input logic w, input logic [31:0] a,
                     input logic [3:0] se, input logic [31:0] d, input logic [2:0] ct,
                     input logic [1:0] bt);
    cyc = c; stb = s; we = w; adr = a; sel = se; dat_ms = d; cti = ct; bte = bt;
  endtask

  task automatic idle_cycle();
    bus(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 3'b000, 2'b00);
    @(negedge clk);
    check("idle_no_ack", {ack, err}, 2'b00);
    step();
  endtask

  // Word visited at beat k of a burst starting at word 'start'.
  function automatic int beat_word(input int start, input int k, input logic [1:0] bt);
    int n;
    if (bt == 2'b00) return (start + k) % DEPTH;
    n = 2 << bt;
    return (start / n) * n + ((start % n) + k) % n;
  endfunction

  task automatic write_op(input logic [31:0] a, input logic [3:0] se, input logic [31:0] d,
                          input bit exp_err);
    int w;
    bus(1'b1, 1'b1, 1'b1, a, se, d, 3'b000, 2'b00);
    @(negedge clk);
    check("wr_resp", {ack, err}, exp_err ? 2'b01 : 2'b10);
    if (!exp_err) begin
      w = int'(a[AW+1:2]);
      for (int i = 0; i < 4; i++) if (se[i]) ref_mem[w][i*8 +: 8] = d[i*8 +: 8];
    end
    step();
    bus(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 3'b000, 2'b00);
  endtask

  task automatic read_op(input logic [31:0] a, input logic [31:0] exp, input bit exp_err);
    bus(1'b1, 1'b1, 1'b0, a, 4'h0, 32'h0, 3'b000, 2'b00);
    @(negedge clk);
    check("rd_latency", {ack, err}, 2'b00);
    step();
    @(negedge clk);
    check("rd_resp", {ack, err}, exp_err ? 2'b01 : 2'b10);
    if (!exp_err) check("rd_data", dat_sm, exp);
    step();
    bus(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 3'b000, 2'b00);
  endtask

  // Master that advances one beat per ack; the first beat and any jumped-to
  // address see one cycle of latency, stalls hold stb low for stall_len cycles.
  task automatic burst(input int start, input int n, input logic [1:0] bt,
                       input int stall_at, input int stall_len,
                       input int jump_at, input int jump_word,
                       input bit no_end, input bit keep_cyc);
    int k = 0;
    int stall = 0;
    int cycles = 0;
    int w;
    bit lat = 1'b1;
    bit exp_ack;
    while (k < n && cycles < 4 * n + stall_len + 8) begin
      w = (jump_at > 0 && k >= jump_at) ? beat_word(jump_word, k - jump_at, bt)
                                        : beat_word(start, k, bt);
      if (stall > 0) begin
        bus(1'b1, 1'b0, 1'b0, 32'(w) << 2, 4'h0, 32'h0, 3'b010, bt);
        exp_ack = 1'b0;
        stall--;
      end else begin
        bus(1'b1, 1'b1, 1'b0, 32'(w) << 2, 4'h0, 32'h0,
            (k == n - 1 && !no_end) ? 3'b111 : 3'b010, bt);
        exp_ack = !lat;
      end
      @(negedge clk);
      check("bst_ack", ack, exp_ack);
      if (exp_ack) begin
        check("bst_data", dat_sm, ref_mem[w]);
        k++;
        if (k == stall_at) stall = stall_len;
        if (jump_at > 0 && k == jump_at) lat = 1'b1;
      end else if (stb) begin
        lat = 1'b0;
      end
      step();
      cycles++;
    end
    if (k < n) begin
      n_checks++;
      n_fail++;
      $display("FAIL bst_timeout: %0d of %0d beats", k, n);
    end
    if (!keep_cyc) idle_cycle();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int op, w, n, bt_i, st_at, st_len, j_at, j_word, m, pred;
    bit ne, kc;
    logic [1:0] bt;

    rst_n = 1'b0;
    bus(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 3'b000, 2'b00);
    #2;
    check("rst_ack", ack, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_rty", rty, 1'b0);
    check("rst_dat", dat_sm, 32'h0);
    step();
    step();
    rst_n = 1'b1;

    for (int i = 0; i < DEPTH; i++) write_op(32'(i) << 2, 4'hF, 32'(i), 1'b0);

    vecs[0]  = '{1'b1, 32'h0000_0010, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0020, 4'hF, 32'h11223344, 32'h0, 1'b0};
    vecs[3]  = '{1'b1, 32'h0000_0020, 4'h1, 32'h000000AA, 32'h0, 1'b0};
    vecs[4]  = '{1'b0, 32'h0000_0020, 4'h0, 32'h0, 32'h112233AA, 1'b0};
    vecs[5]  = '{1'b1, 32'h0000_0024, 4'hF, 32'hFFFFFFFF, 32'h0, 1'b0};
    vecs[6]  = '{1'b1, 32'h0000_0024, 4'h2, 32'h00005500, 32'h0, 1'b0};
    vecs[7]  = '{1'b0, 32'h0000_0024, 4'h0, 32'h0, 32'hFFFF55FF, 1'b0};
    vecs[8]  = '{1'b1, 32'h0000_0028, 4'hC, 32'h12345678, 32'h0, 1'b0};
    vecs[9]  = '{1'b0, 32'h0000_0028, 4'h0, 32'h0, 32'h1234000A, 1'b0};
    vecs[10] = '{1'b1, 32'h0000_1FFC, 4'hF, 32'h87654321, 32'h0, 1'b0};
    vecs[11] = '{1'b0, 32'h0000_1FFC, 4'h0, 32'h0, 32'h87654321, 1'b0};
    vecs[12] = '{1'b0, 32'h0000_2000, 4'h0, 32'h0, 32'h0, ADR_CHECK};
    vecs[13] = '{1'b1, 32'h0000_2030, 4'hF, 32'h5A5A5A5A, 32'h0, ADR_CHECK};
    vecs[14] = '{1'b0, 32'h0000_0030, 4'h0, 32'h0, ADR_CHECK ? 32'h0000000C : 32'h5A5A5A5A, 1'b0};
    vecs[15] = '{1'b0, 32'h8000_0010, 4'h0, 32'h0, 32'hDEADBEEF, ADR_CHECK};
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].we) write_op(vecs[i].adr, vecs[i].sel, vecs[i].wdat, vecs[i].exp_err);
      else            read_op(vecs[i].adr, vecs[i].exp, vecs[i].exp_err);
    end

    // Linear 8-beat burst from word 0, then a read of word 8 must see fresh latency.
    burst(0, 8, 2'b00, 0, 0, 0, 0, 1'b0, 1'b0);
    read_op(32'h20, ref_mem[8], 1'b0);
    // Wrap-4 from word 6 (6,7,4,5) with a two-cycle master wait after beat 2.
    burst(6, 4, 2'b01, 2, 2, 0, 0, 1'b0, 1'b0);
    // Address discontinuity at beat 3.
    burst(100, 6, 2'b00, 0, 0, 3, 300, 1'b0, 1'b0);
    // cyc dropped mid-burst; the predicted next word must not be acked early.
    burst(200, 3, 2'b00, 0, 0, 0, 0, 1'b1, 1'b0);
    read_op(32'(203) << 2, ref_mem[203], 1'b0);
    // Write arriving inside a wrap-8 burst.
    burst(210, 3, 2'b10, 0, 0, 0, 0, 1'b1, 1'b1);
    write_op(32'(500) << 2, 4'hF, 32'hA5A50001, 1'b0);
    read_op(32'(213) << 2, ref_mem[213], 1'b0);
    read_op(32'(500) << 2, 32'hA5A50001, 1'b0);

`ifdef WB_BRAM_ADR_CHECK_EN
    bus(1'b1, 1'b1, 1'b0, 32'(2047) << 2, 4'h0, 32'h0, 3'b010, 2'b00);
    @(negedge clk); check("top_lat", {ack, err}, 2'b00); step();
    @(negedge clk); check("top_ack", {ack, err}, 2'b10); check("top_data", dat_sm, ref_mem[2047]); step();
    bus(1'b1, 1'b1, 1'b0, 32'h0000_2000, 4'h0, 32'h0, 3'b111, 2'b00);
    @(negedge clk); check("top_err", {ack, err}, 2'b01); step();
    idle_cycle();
`else
    burst(2046, 4, 2'b00, 0, 0, 0, 0, 1'b0, 1'b0);
`endif

    // Reset in the middle of beat 3 of a linear burst.
    bus(1'b1, 1'b1, 1'b0, 32'(40) << 2, 4'h0, 32'h0, 3'b010, 2'b00);
    step();
    step();
    bus(1'b1, 1'b1, 1'b0, 32'(41) << 2, 4'h0, 32'h0, 3'b010, 2'b00);
    step();
    bus(1'b1, 1'b1, 1'b0, 32'(42) << 2, 4'h0, 32'h0, 3'b010, 2'b00);
    #1;
    check("mid_beat_ack", ack, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ack", ack, 1'b0);
    check("mid_rst_dat", dat_sm, 32'h0);
    bus(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 3'b000, 2'b00);
    step();
    step();
    rst_n = 1'b1;
    read_op(32'(40) << 2, ref_mem[40], 1'b0);

    m = ADR_CHECK ? DEPTH - 64 : DEPTH;
    for (int it = 0; it < 200; it++) begin
      op = $urandom_range(0, 3);
      if (op == 0) begin
        write_op(32'($urandom_range(0, m - 1)) << 2, 4'($urandom), $urandom, 1'b0);
      end else if (op == 1) begin
        w = $urandom_range(0, m - 1);
        read_op(32'(w) << 2, ref_mem[w], 1'b0);
      end else begin
        bt_i   = $urandom_range(0, 3);
        bt     = 2'(bt_i);
        n      = $urandom_range(1, 16);
        w      = $urandom_range(0, m - 1);
        st_at  = 0;
        st_len = 0;
        j_at   = 0;
        j_word = 0;
        if ($urandom_range(0, 1) == 1) begin
          st_at  = $urandom_range(1, n);
          st_len = $urandom_range(1, 3);
        end
        if (n >= 3 && $urandom_range(0, 1) == 1) begin
          j_at   = $urandom_range(1, n - 1);
          pred   = beat_word(w, j_at, bt);
          j_word = (pred + 1 + $urandom_range(0, m - 2)) % m;
        end
        ne = $urandom_range(0, 1) == 1;
        kc = !ne && ($urandom_range(0, 1) == 1);
        burst(w, n, bt, st_at, st_len, j_at, j_word, ne, kc);
      end
    end
    idle_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
